// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mem_arb_pkg
//  Purpose : Shared types for the instruction/data memory arbiter.
//            Holds the arbiter FSM state encoding and the access owner tag.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_D = 2'd1,
    GNT_I = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Encoding matters: the owner latch stores the raw bit, 1 = data port.
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/flopenr.sv
`default_nettype none
// ============================================================================
//  Module  : flopenr
//  Purpose : Enabled register with asynchronous active-high reset to zero.
//  Ports   : clk   - rising-edge clock
//            reset - asynchronous active-high reset
//            en    - load enable
//            d     - next value
//            q     - registered value
//  Rev     : 1.0  initial release
// ============================================================================
module flopenr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : flopenr
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : mem_arbiter
//  Purpose : Shares one single-ported, variable-latency memory between the
//            instruction-fetch port and the data port. Data wins ties unless
//            fetch has been passed over STARVE_LIMIT times in a row.
//  Ports   : clk, reset                 - clock, async active-high reset
//            if_req/if_addr             - fetch request and byte address
//            if_rdata/if_done           - fetched word and completion pulse
//            d_req/d_we/d_addr/d_wdata  - data request, store flag, addr, data
//            d_rdata/d_done             - load word and completion pulse
//            mem_req/mem_we/mem_addr/mem_wdata - memory request side
//            mem_rdata/mem_ready        - memory response side
//            busy_if/busy_d             - request pending (stall drivers)
//  Rev     : 1.0  initial release
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [WORD_W-1:0] if_addr,
  output logic [WORD_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [WORD_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic [WORD_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy_if,
  output logic              busy_d
);

  localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_t         state_q, state_d;
  logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;

  logic               starved;
  logic               grant_d;
  logic               grant_i;
  logic               grant;

  logic [WORD_W-1:0]  lat_addr_d;
  logic [WORD_W-1:0]  lat_wdata_d;
  logic               lat_we_d;

  logic [WORD_W-1:0]  addr_q;
  logic [WORD_W-1:0]  wdata_q;
  logic               we_q;
  logic               owner_bit_q;
  owner_t             owner_q;

  logic               cap_i;
  logic               cap_d;

  // Byte-offset bits never reach the memory (word-aligned access).
  logic               unused_addr_lsbs;
  assign unused_addr_lsbs = ^{if_addr[1:0], d_addr[1:0]};

  // --------------------------------------------------------------------------
  // Arbitration decision, only meaningful in IDLE
  // --------------------------------------------------------------------------
  always_comb begin
    starved = if_req && (starve_cnt_q == CNT_MAX);
    grant_d = (state_q == IDLE) && d_req && !starved;
    grant_i = (state_q == IDLE) && !grant_d && if_req;
    grant   = grant_d || grant_i;
  end

  // Winner's request fields, captured once at grant time.
  always_comb begin
    lat_addr_d  = grant_d ? {d_addr[31:2], 2'b00} : {if_addr[31:2], 2'b00};
    lat_we_d    = grant_d && d_we;
    lat_wdata_d = grant_d ? d_wdata : '0;
  end

  flopenr #(.WIDTH(WORD_W)) u_addr_reg (
    .clk   (clk),
    .reset (reset),
    .en    (grant),
    .d     (lat_addr_d),
    .q     (addr_q)
  );

  flopenr #(.WIDTH(WORD_W)) u_wdata_reg (
    .clk   (clk),
    .reset (reset),
    .en    (grant),
    .d     (lat_wdata_d),
    .q     (wdata_q)
  );

  flopenr #(.WIDTH(1)) u_we_reg (
    .clk   (clk),
    .reset (reset),
    .en    (grant),
    .d     (lat_we_d),
    .q     (we_q)
  );

  flopenr #(.WIDTH(1)) u_owner_reg (
    .clk   (clk),
    .reset (reset),
    .en    (grant),
    .d     (grant_d),
    .q     (owner_bit_q)
  );

  assign owner_q = owner_t'(owner_bit_q);

  // --------------------------------------------------------------------------
  // FSM state register and starvation counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    mem_req      = 1'b0;
    if_done      = 1'b0;
    d_done       = 1'b0;

    case (state_q)
      IDLE: begin
        // Counter only tracks data grants that actually pushed fetch back.
        if (!if_req || grant_i) begin
          starve_cnt_d = '0;
        end else if (grant_d && (starve_cnt_q != CNT_MAX)) begin
          starve_cnt_d = starve_cnt_q + CNT_ONE;
        end

        if (grant_d) begin
          state_d = GNT_D;
        end else if (grant_i) begin
          state_d = GNT_I;
        end
      end

      GNT_D, GNT_I: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          state_d = RESP;
        end
      end

      RESP: begin
        if_done = (owner_q == OWN_I);
        d_done  = (owner_q == OWN_D);
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Read-data capture; registers hold outside the done cycle
  // --------------------------------------------------------------------------
  assign cap_i = mem_req && mem_ready && (owner_q == OWN_I);
  assign cap_d = mem_req && mem_ready && (owner_q == OWN_D);

  flopenr #(.WIDTH(WORD_W)) u_if_rdata_reg (
    .clk   (clk),
    .reset (reset),
    .en    (cap_i),
    .d     (mem_rdata),
    .q     (if_rdata)
  );

  flopenr #(.WIDTH(WORD_W)) u_d_rdata_reg (
    .clk   (clk),
    .reset (reset),
    .en    (cap_d),
    .d     (mem_rdata),
    .q     (d_rdata)
  );

  // Write enable is only asserted alongside an outstanding request.
  assign mem_we    = mem_req && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign busy_if   = if_req && !if_done;
  assign busy_d    = d_req && !d_done;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_mem_arbiter
//  Purpose : Self-checking bench for mem_arbiter: directed scenarios with
//            literal expectations plus randomized traffic compared every
//            cycle against a transaction-level model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        busy_if;
  logic        busy_d;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .busy_if   (busy_if),
    .busy_d    (busy_d)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Transaction-level model: one access in flight at a time, described as
  // "waiting for memory" then "reporting done", plus the starvation tally.
  // --------------------------------------------------------------------------
  logic        m_busy = 1'b0;   // an access has been granted and not finished
  logic        m_resp = 1'b0;   // memory answered; done is being reported
  logic        m_isd  = 1'b0;
  logic        m_we   = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_ifr  = '0;
  logic [31:0] m_dr   = '0;
  int          m_cnt  = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0; m_resp = 1'b0; m_isd = 1'b0; m_we = 1'b0;
      m_addr = '0; m_wdata = '0; m_ifr = '0; m_dr = '0; m_cnt = 0;
    end else if (m_resp) begin
      m_resp = 1'b0;
      m_busy = 1'b0;
    end else if (m_busy) begin
      if (mem_ready) begin
        if (m_isd) m_dr = mem_rdata;
        else       m_ifr = mem_rdata;
        m_resp = 1'b1;
      end
    end else begin
      if (d_req && !(if_req && m_cnt == LIMIT)) begin
        m_busy = 1'b1; m_isd = 1'b1; m_we = d_we;
        m_addr = d_addr & 32'hFFFF_FFFC; m_wdata = d_wdata;
        m_cnt = if_req ? ((m_cnt + 1 > LIMIT) ? LIMIT : m_cnt + 1) : 0;
      end else if (if_req) begin
        m_busy = 1'b1; m_isd = 1'b0; m_we = 1'b0;
        m_addr = if_addr & 32'hFFFF_FFFC;
        m_cnt = 0;
      end else begin
        m_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("mem_req", {31'd0, mem_req}, {31'd0, m_busy && !m_resp});
      if (m_busy && !m_resp) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_we", {31'd0, mem_we}, {31'd0, m_we});
        if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
      end else begin
        chk("mem_we_idle", {31'd0, mem_we}, 32'd0);
      end
      chk("if_done", {31'd0, if_done}, {31'd0, m_resp && !m_isd});
      chk("d_done", {31'd0, d_done}, {31'd0, m_resp && m_isd});
      chk("if_rdata", if_rdata, m_ifr);
      chk("d_rdata", d_rdata, m_dr);
      chk("busy_if", {31'd0, busy_if}, {31'd0, if_req && !(m_resp && !m_isd)});
      chk("busy_d", {31'd0, busy_d}, {31'd0, d_req && !(m_resp && m_isd)});
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Serve whatever is outstanding and return to a quiet IDLE.
  task automatic drain();
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 60 && !ok; c++) begin
      cycle();
      mem_ready = mem_req;
      if (if_done) if_req = 1'b0;
      if (d_done)  d_req  = 1'b0;
      if (!if_req && !d_req && !mem_req && !if_done && !d_done) ok = 1'b1;
    end
    mem_ready = 1'b0;
    if (!ok) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int nd;
    int nd_before;
    int phase;
    logic prev;
    logic next_is_d;

    // ---------------- Reset values ----------------
    reset = 1'b1;
    cycle(); cycle();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_if_done", {31'd0, if_done}, 32'd0);
    chk("rst_d_done", {31'd0, d_done}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    reset = 1'b0;
    chk_en = 1'b1;
    cycle();

    // ---------------- Single fetch ----------------
    if_req = 1'b1; if_addr = 32'h0000_0044;
    cycle();
    chk("fetch_mem_req", {31'd0, mem_req}, 32'd1);
    chk("fetch_mem_addr", mem_addr, 32'h44);
    chk("fetch_mem_we", {31'd0, mem_we}, 32'd0);
    mem_ready = 1'b1; mem_rdata = 32'h8C08_0004;
    cycle();
    chk("fetch_done", {31'd0, if_done}, 32'd1);
    chk("fetch_rdata", if_rdata, 32'h8C08_0004);
    chk("fetch_mem_req_dropped", {31'd0, mem_req}, 32'd0);
    if_req = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0;
    cycle();
    chk("fetch_done_once", {31'd0, if_done}, 32'd0);
    chk("fetch_rdata_hold", if_rdata, 32'h8C08_0004);

    // ---------------- Load, 3 wait cycles ----------------
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_1003;
    cycle();
    chk("load_mem_addr", mem_addr, 32'h1000);
    cycle();
    chk("load_wait2_req", {31'd0, mem_req}, 32'd1);
    chk("load_wait2_done", {31'd0, d_done}, 32'd0);
    cycle();
    chk("load_wait3_req", {31'd0, mem_req}, 32'd1);
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_0123;
    cycle();
    chk("load_done", {31'd0, d_done}, 32'd1);
    chk("load_rdata", d_rdata, 32'hCAFE_0123);
    d_req = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h5555_AAAA;
    cycle();
    chk("load_rdata_hold", d_rdata, 32'hCAFE_0123);

    // ---------------- Store; later requester changes are ignored ----------
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
    cycle();
    chk("store_mem_we", {31'd0, mem_we}, 32'd1);
    chk("store_wdata", mem_wdata, 32'hDEAD_BEEF);
    d_wdata = 32'h1111_1111; d_addr = 32'h80;
    cycle();
    chk("store_wdata_held", mem_wdata, 32'hDEAD_BEEF);
    chk("store_addr_held", mem_addr, 32'h20);
    mem_ready = 1'b1;
    cycle();
    chk("store_done", {31'd0, d_done}, 32'd1);
    d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    drain();

    // ---------------- Collision ----------------
    d_req = 1'b1; d_addr = 32'h300; if_req = 1'b1; if_addr = 32'h400;
    cycle();
    chk("coll_first_is_data", mem_addr, 32'h300);
    chk("coll_busy_if_1", {31'd0, busy_if}, 32'd1);
    cycle();
    chk("coll_busy_if_2", {31'd0, busy_if}, 32'd1);
    mem_ready = 1'b1;
    cycle();
    chk("coll_d_done", {31'd0, d_done}, 32'd1);
    chk("coll_busy_if_3", {31'd0, busy_if}, 32'd1);
    d_req = 1'b0; mem_ready = 1'b0;
    cycle();
    chk("coll_busy_if_4", {31'd0, busy_if}, 32'd1);
    cycle();
    chk("coll_then_fetch", mem_addr, 32'h400);
    chk("coll_fetch_req", {31'd0, mem_req}, 32'd1);
    drain();

    // ---------------- Starvation ----------------
    nd = 0; nd_before = -1; phase = 0; prev = 1'b0; next_is_d = 1'b0;
    d_addr = 32'h100; if_addr = 32'h200; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    for (int c = 0; c < 200 && phase < 2; c++) begin
      cycle();
      if (mem_req && !prev) begin
        if (phase == 0) begin
          if (mem_addr == 32'h100) nd++;
          else begin nd_before = nd; phase = 1; end
        end else begin
          next_is_d = (mem_addr == 32'h100);
          phase = 2;
        end
      end
      prev = mem_req;
      mem_ready = mem_req;
      d_req  = !d_done;
      if_req = !if_done;
    end
    chk("starve_reached_end", phase, 32'd2);
    chk("starve_data_grants", nd_before, LIMIT);
    chk("starve_cleared_next_data", {31'd0, next_is_d}, 32'd1);
    drain();

    // ---------------- Reset mid-access ----------------
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h500; d_wdata = 32'h5;
    cycle();
    chk("rstmid_req_up", {31'd0, mem_req}, 32'd1);
    cycle();
    reset = 1'b1;
    #1;
    chk("rstmid_req_async_drop", {31'd0, mem_req}, 32'd0);
    d_req = 1'b0;
    cycle(); cycle();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cycle();
      chk("rstmid_no_done", {31'd0, d_done}, 32'd0);
      chk("rstmid_no_req", {31'd0, mem_req}, 32'd0);
    end
    if_req = 1'b1; if_addr = 32'h600;
    cycle();
    chk("rstmid_idle_then_grant", mem_addr, 32'h600);
    drain();

    // ---------------- Randomized traffic ----------------
    for (int c = 0; c < 6000; c++) begin
      cycle();
      mem_ready = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      if (if_req) begin
        if (if_done || $urandom_range(0, 63) == 0) if_req = 1'b0;
      end else if ($urandom_range(0, 1) == 0) begin
        if_req = 1'b1; if_addr = $urandom;
      end
      if (d_req) begin
        if (d_done || $urandom_range(0, 63) == 0) d_req = 1'b0;
      end else if ($urandom_range(0, 3) != 0) begin
        d_req = 1'b1; d_addr = $urandom; d_we = 1'($urandom_range(0, 1));
        d_wdata = $urandom;
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mem_arbiter
`default_nettype wire
